// File: rtl/update_dispatcher.sv
// ==========================================================================
// update_dispatcher: buffers edge-weight updates and issues them one at a time to the container. Rev 1.0
// ==========================================================================
`default_nettype none

module update_dispatcher #(
  parameter int PRED_BITS   = 5,
  parameter int WEIGHT_BITS = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     upd_valid,
  input  logic [PRED_BITS-1:0]     upd_src,
  input  logic [PRED_BITS-1:0]     upd_dst,
  input  logic [WEIGHT_BITS-1:0]   upd_e,
  output logic                     upd_ready,
  output logic                     container_reset,
  output logic [PRED_BITS-1:0]     u_src,
  output logic [PRED_BITS-1:0]     u_dst,
  output logic [WEIGHT_BITS-1:0]   u_e,
  input  logic                     container_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              updates_done,
  output logic [7:0]               rejected,
  output logic                     err_timeout
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int EW  = 2 * PRED_BITS + WEIGHT_BITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  // The container negates the weight for the reverse edge, so the most
  // negative value has no representable negation and must be filtered.
  localparam logic [WEIGHT_BITS-1:0] W_MIN   = {1'b1, {(WEIGHT_BITS-1){1'b0}}};
  localparam logic [WDW-1:0]         WD_LAST = WDW'(TIMEOUT - 1);

  logic [EW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q;
  logic [1:0]             state_q, state_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   err_q, err_d;
  logic [15:0]            done_cnt_q;
  logic [7:0]             rej_cnt_q;
  logic [PRED_BITS-1:0]   u_src_q, u_dst_q;
  logic [WEIGHT_BITS-1:0] u_e_q;

  logic accept, illegal, push, pop, done_inc;

  assign upd_ready = (level_q < LW'(DEPTH));
  assign accept    = upd_valid && upd_ready;
  assign illegal   = (upd_src == upd_dst) || (upd_e == W_MIN);
  assign push      = accept && !illegal;

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    err_d    = err_q;
    pop      = 1'b0;
    done_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GUARD;
      S_GUARD: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WDW'(1);
        if (container_done) begin
          done_inc = 1'b1;
          state_d  = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {upd_src, upd_dst, upd_e};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
      rej_cnt_q  <= '0;
      u_src_q    <= '0;
      u_dst_q    <= '0;
      u_e_q      <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q                   <= rd_ptr_q + AW'(1);
        {u_src_q, u_dst_q, u_e_q}  <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (done_inc) done_cnt_q <= done_cnt_q + 16'd1;
      if (accept && illegal && (rej_cnt_q != 8'hFF)) rej_cnt_q <= rej_cnt_q + 8'd1;
    end
  end

  assign container_reset = (state_q == S_ISSUE);
  assign busy            = (level_q != '0) || (state_q != S_IDLE);
  assign fifo_level      = level_q;
  assign updates_done    = done_cnt_q;
  assign rejected        = rej_cnt_q;
  assign err_timeout     = err_q;
  assign u_src           = u_src_q;
  assign u_dst           = u_dst_q;
  assign u_e             = u_e_q;

endmodule

`default_nettype wire

// File: tb/tb_update_dispatcher.sv
// ==========================================================================
// tb_update_dispatcher: scoreboard bench for update_dispatcher. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_update_dispatcher;

  localparam int PB = 5;
  localparam int WB = 32;
  localparam int DP = 8;
  localparam int TO = 20;
  localparam logic [WB-1:0] W_MIN = 32'h8000_0000;

  localparam int M_LOW  = 0;
  localparam int M_HIGH = 1;
  localparam int M_AUTO = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          upd_valid = 1'b0;
  logic [PB-1:0] upd_src = '0, upd_dst = '0;
  logic [WB-1:0] upd_e = '0;
  logic          upd_ready, container_reset, busy, err_timeout;
  logic [PB-1:0] u_src, u_dst;
  logic [WB-1:0] u_e;
  logic          container_done = 1'b0;
  logic [3:0]    fifo_level;
  logic [15:0]   updates_done;
  logic [7:0]    rejected;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int pulses = 0;
  int last_pulse = -100;
  int mode = M_LOW;
  int dlay = 10;
  int dcnt = 0;
  logic [2*PB+WB-1:0] exp_q [$];

  update_dispatcher #(.PRED_BITS(PB), .WEIGHT_BITS(WB), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_src(upd_src), .upd_dst(upd_dst),
    .upd_e(upd_e), .upd_ready(upd_ready), .container_reset(container_reset), .u_src(u_src),
    .u_dst(u_dst), .u_e(u_e), .container_done(container_done), .busy(busy),
    .fifo_level(fifo_level), .updates_done(updates_done), .rejected(rejected),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Container model plus scoreboard pop on every start pulse.
  always @(negedge clk) begin
    logic [2*PB+WB-1:0] exp_v;
    cycle++;
    if (mode == M_LOW) container_done = 1'b0;
    if (mode == M_HIGH) container_done = 1'b1;
    if (container_reset) begin
      pulses++;
      if (last_pulse >= 0) begin
        tests++;
        if (cycle - last_pulse < 3) begin
          fails++;
          $display("FAIL pulse_gap: gap=%0d required >=3", cycle - last_pulse);
        end
      end
      last_pulse = cycle;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: u=%0d/%0d/%0d with empty scoreboard", u_src, u_dst, u_e);
      end else begin
        exp_v = exp_q.pop_front();
        if ({u_src, u_dst, u_e} !== exp_v) begin
          fails++;
          $display("FAIL issue_order: got %0d/%0d/%0d required %0d/%0d/%0d", u_src, u_dst, u_e,
                   exp_v[2*PB+WB-1 -: PB], exp_v[PB+WB-1 -: PB], exp_v[WB-1:0]);
        end
      end
      if (mode == M_AUTO) begin
        container_done = 1'b0;
        dcnt = dlay;
      end
    end else if (mode == M_AUTO && dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) container_done = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [PB-1:0] s, input logic [PB-1:0] d, input logic [WB-1:0] e);
    int n;
    n = 0;
    upd_valid = 1'b1;
    upd_src = s;
    upd_dst = d;
    upd_e = e;
    while (!upd_ready && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (upd_ready !== 1'b1) begin
      fails++;
      $display("FAIL offer_ready: upd_ready=%b required 1", upd_ready);
    end
    if (s != d && e != W_MIN) exp_q.push_back({s, d, e});
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int bound);
    int n;
    n = 0;
    while (pulses < target && n < bound) begin
      tick();
      n++;
    end
    tests++;
    if (pulses < target) begin
      fails++;
      $display("FAIL wait_pulses: pulses=%0d required %0d", pulses, target);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode = M_LOW;
    repeat (3) tick();
    tests++;
    if ({upd_ready, container_reset, busy, err_timeout} !== 4'b1000 || fifo_level !== 4'd0 ||
        updates_done !== 16'd0 || rejected !== 8'd0 || {u_src, u_dst, u_e} !== '0) begin
      fails++;
      $display("FAIL reset_values: ready=%b crst=%b busy=%b err=%b lvl=%0d done=%0d rej=%0d required 1,0,0,0,0,0,0",
               upd_ready, container_reset, busy, err_timeout, fifo_level, updates_done, rejected);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int c0, p0;
    logic stable;
    mode = M_AUTO;
    dlay = 10;
    p0 = pulses;
    c0 = cycle;
    offer(5'd1, 5'd2, 32'd100);
    wait_pulses(p0 + 1, 10);
    tests++;
    if (last_pulse != c0 + 2) begin
      fails++;
      $display("FAIL single_latency: pulse at +%0d required +2", last_pulse - c0);
    end
    stable = 1'b1;
    for (int i = 0; i < 30 && busy; i++) begin
      if (u_src !== 5'd1 || u_dst !== 5'd2 || u_e !== 32'd100) stable = 1'b0;
      tick();
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("FAIL single_stable: u_* changed, now %0d/%0d/%0d required 1/2/100", u_src, u_dst, u_e);
    end
    wait_idle(20);
    tests++;
    if (updates_done !== 16'd1 || pulses != p0 + 1 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL single_done: done=%0d pulses=%0d err=%b required 1,%0d,0",
               updates_done, pulses - p0, err_timeout, 1);
    end
  endtask

  task automatic test_fill();
    int p0;
    logic [15:0] ud0;
    mode = M_LOW;
    p0 = pulses;
    ud0 = updates_done;
    for (int i = 0; i < 9; i++) offer(PB'(i + 1), PB'(i + 10), WB'(1000 + i));
    tests++;
    if (fifo_level !== 4'd8 || upd_ready !== 1'b0 || pulses != p0 + 1) begin
      fails++;
      $display("FAIL fill_full: level=%0d ready=%b pulses=%0d required 8,0,1",
               fifo_level, upd_ready, pulses - p0);
    end
    dlay = 2;
    dcnt = 2;
    mode = M_AUTO;
    wait_pulses(p0 + 9, 200);
    wait_idle(20);
    tests++;
    if (updates_done !== ud0 + 16'd9 || fifo_level !== 4'd0 || pulses != p0 + 9) begin
      fails++;
      $display("FAIL fill_drain: done_delta=%0d level=%0d pulses=%0d required 9,0,9",
               updates_done - ud0, fifo_level, pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [15:0] ud0;
    mode = M_HIGH;
    p0 = pulses;
    ud0 = updates_done;
    offer(5'd3, 5'd4, 32'hFFFF_FFF0);
    offer(5'd4, 5'd5, 32'h7FFF_FFFF);
    offer(5'd5, 5'd6, 32'd0);
    wait_pulses(p0 + 3, 60);
    wait_idle(20);
    tests++;
    if (updates_done !== ud0 + 16'd3 || pulses != p0 + 3) begin
      fails++;
      $display("FAIL b2b_done: done_delta=%0d pulses=%0d required 3,3", updates_done - ud0, pulses - p0);
    end
  endtask

  task automatic test_filter();
    int p0;
    logic [7:0] rj0;
    mode = M_AUTO;
    dlay = 3;
    p0 = pulses;
    rj0 = rejected;
    offer(5'd3, 5'd3, 32'd5);
    offer(5'd1, 5'd4, W_MIN);
    tests++;
    if (rejected !== rj0 + 8'd2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL filter_reject: rej_delta=%0d busy=%b required 2,0", rejected - rj0, busy);
    end
    offer(5'd5, 5'd6, 32'd77);
    wait_idle(40);
    tests++;
    if (pulses != p0 + 1 || rejected !== rj0 + 8'd2) begin
      fails++;
      $display("FAIL filter_issue: pulses=%0d rej_delta=%0d required 1,2", pulses - p0, rejected - rj0);
    end
  endtask

  task automatic test_timeout();
    int p0, n, ec, pc;
    logic [15:0] ud0;
    mode = M_LOW;
    p0 = pulses;
    ud0 = updates_done;
    offer(5'd7, 5'd8, 32'd9);
    offer(5'd9, 5'd10, 32'd11);
    n = 0;
    while (!err_timeout && n < 60) begin
      tick();
      n++;
    end
    ec = cycle;
    pc = last_pulse;
    tests++;
    if (err_timeout !== 1'b1 || ec - pc != TO + 2) begin
      fails++;
      $display("FAIL timeout_time: err=%b at +%0d after pulse required 1 at +%0d", err_timeout, ec - pc, TO + 2);
    end
    tests++;
    if (updates_done !== ud0) begin
      fails++;
      $display("FAIL timeout_count: done=%0d required %0d", updates_done, ud0);
    end
    wait_pulses(p0 + 2, 10);
    mode = M_HIGH;
    wait_idle(20);
    tests++;
    if (updates_done !== ud0 + 16'd1 || err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_resume: done_delta=%0d err=%b required 1,1", updates_done - ud0, err_timeout);
    end
  endtask

  task automatic test_mid_reset();
    int p0;
    mode = M_LOW;
    for (int i = 0; i < 4; i++) offer(PB'(i + 1), PB'(i + 2), WB'(i + 1));
    tick();
    tick();
    tests++;
    if (fifo_level !== 4'd3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: level=%0d busy=%b required 3,1", fifo_level, busy);
    end
    reset = 1'b1;
    tick();
    exp_q.delete();
    last_pulse = -100;
    p0 = pulses;
    tests++;
    if (fifo_level !== 4'd0 || busy !== 1'b0 || container_reset !== 1'b0 || updates_done !== 16'd0 ||
        rejected !== 8'd0 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL midrst_state: level=%0d busy=%b crst=%b done=%0d rej=%0d err=%b required all 0",
               fifo_level, busy, container_reset, updates_done, rejected, err_timeout);
    end
    reset = 1'b0;
    repeat (10) tick();
    tests++;
    if (pulses != p0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_quiet: pulses=%0d busy=%b required 0,0", pulses - p0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_filter();
    test_timeout();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
